exec_arith_port: RTL and testbench
==================================

EXEC_ARITH_PORT -- requirements
Module: exec_arith_port

Interface
REQ-001 SHALL have parameter MUL_STEPS, default 4, giving the multiply iteration count at 4 operand bits per step.
REQ-002 SHALL have port clock_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush_i  input  1  synchronous pipeline flush.
REQ-005 SHALL have port enable_i  input  1  issue valid from the register controller lane.
REQ-006 SHALL have port wb_i  input  1  issued op requests writeback.
REQ-007 SHALL have port opCode_i  input  7  operation code.
REQ-008 SHALL have port regAddr_i  input  5  destination register.
REQ-009 SHALL have ports primOperand_i / secOperand_i  input  16 each  resolved operands.
REQ-010 SHALL have port functionType_i  input  2  unit select; 0 = arithmetic.
REQ-011 SHALL have port operationStatus_i  input  2  incoming flags, with bit0 = carry and bit1 = zero.
REQ-012 SHALL have port wb_o  output  1  one-cycle writeback strobe to the register file.
REQ-013 SHALL have ports wbAddr_o (output, 5) and wbVal_o (output, 16) carrying writeback address and data.
REQ-014 SHALL have port operationStatus_o  output  2  result flags, with bit0 = carry and bit1 = zero.
REQ-015 SHALL have port busy_o  output  1  multi-cycle op in flight.
REQ-016 SHALL have port dropped_o  output  1  sticky flag: an issue was lost while busy.

Function
REQ-017 SHALL accept an op at a rising edge when enable_i=1, busy_o=0 and flush_i=0; an op with functionType_i!=0 SHALL be accepted but SHALL produce no wb_o.
REQ-018 SHALL decode opcodes as: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL by sec[3:0], 7 SHR (logical) by sec[3:0], 8 MUL, 9 ADC (carry-in = operationStatus_i[0]).
REQ-019 SHALL treat any other opcode as illegal: no wb_o, operationStatus_o=2'b11 for one cycle.
REQ-020 SHALL, for single-cycle ops accepted at edge N, drive wb_o=wb_i (forced 0 for NOP) at edge N+1 with wbAddr_o=regAddr_i.
REQ-021 SHALL compute ADD, SUB and ADC at 17 bits: carry = bit16 (for SUB, borrow = prim<sec); zero = (result[15:0]==0); logical and shift ops SHALL clear carry.
REQ-022 SHALL implement MUL as a 4-bit-per-step shift-add FSM with states IDLE -> MUL -> IDLE; wb_o SHALL be presented at edge N+MUL_STEPS with result[15:0]; carry = (result[31:16]!=0).
REQ-023 SHALL hold busy_o=1 from edge N to edge N+MUL_STEPS-1 inclusive; busy_o SHALL be low after the edge that presents the MUL result.
REQ-024 SHALL ignore enable_i=1 while busy_o=1, and SHALL set dropped_o at that edge; dropped_o SHALL clear only on reset.
REQ-025 SHALL hold wb_o high for exactly one cycle per result; wbVal_o, wbAddr_o and operationStatus_o SHALL hold their last values otherwise.
REQ-026 SHALL, on flush_i=1 at any edge, abort the MUL FSM to IDLE, force wb_o=0 at that edge, and not accept enable_i; flush SHALL dominate a simultaneous issue and completion.

Reset
REQ-027 SHALL, while reset_i=0, asynchronously force wb_o=0, wbAddr_o=0, wbVal_o=0, operationStatus_o=0, busy_o=0, dropped_o=0 and FSM=IDLE.
REQ-028 SHALL, on reset asserted mid-MUL, discard the op with no wb_o after release; the first acceptance SHALL occur at the first rising edge after reset_i=1.

Structure
REQ-029 SHALL take opcode constants, functionType codes and status-bit indices from shared package exec_pkg, which the register controller also uses.
REQ-030 SHALL place the iterative multiplier in sub-module exec_mul_seq (start, operands in; done, 32-bit product out), instantiated once.

Verification
REQ-031 ADD 0xFFFF + 0x0001, wb_i=1, regAddr 5 -> next edge wb_o=1, wbAddr 5, wbVal 0x0000, status 2'b11.
REQ-032 MUL 0x0100 x 0x0101, regAddr 3 -> busy_o high 4 cycles, wb_o at edge N+4, wbVal 0x0100, carry=1, zero=0.
REQ-033 Issue ADD while MUL busy -> ADD lost, dropped_o=1 and sticky, MUL result unaffected.
REQ-034 flush_i at MUL step 2 -> no wb_o, busy_o low next cycle, subsequent SUB 3-5 -> wbVal 0xFFFE, carry=1.
REQ-035 Opcode 0x55 with wb_i=1 -> wb_o stays 0, operationStatus_o=2'b11 one cycle.
REQ-036 Assert reset_i=0 mid-MUL, release -> all outputs 0, no late wb_o, ADC 1+1 with carry-in=1 -> wbVal 0x0003.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared execution-lane definitions: opcodes, unit selects and status-flag bit positions.
// Used by the arithmetic port and by the register controller.
package exec_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int OP_W   = 7;

    localparam logic [OP_W-1:0] OP_NOP = 7'd0;
    localparam logic [OP_W-1:0] OP_ADD = 7'd1;
    localparam logic [OP_W-1:0] OP_SUB = 7'd2;
    localparam logic [OP_W-1:0] OP_AND = 7'd3;
    localparam logic [OP_W-1:0] OP_OR  = 7'd4;
    localparam logic [OP_W-1:0] OP_XOR = 7'd5;
    localparam logic [OP_W-1:0] OP_SHL = 7'd6;
    localparam logic [OP_W-1:0] OP_SHR = 7'd7;
    localparam logic [OP_W-1:0] OP_MUL = 7'd8;
    localparam logic [OP_W-1:0] OP_ADC = 7'd9;

    localparam logic [1:0] FT_ARITH = 2'd0;
    localparam logic [1:0] FT_LOAD  = 2'd1;
    localparam logic [1:0] FT_STORE = 2'd2;
    localparam logic [1:0] FT_JUMP  = 2'd3;

    localparam int STAT_CARRY = 0;
    localparam int STAT_ZERO  = 1;

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic              carry;
        logic              zero;
    } aluRes_t;

    function automatic logic isArithOp(input logic [OP_W-1:0] op);
        return op <= OP_ADC;
    endfunction

endpackage

// File: rtl/exec_arith_port_if.sv
// Issue and writeback bus between the register controller lane and the arithmetic port.
interface exec_arith_port_if;
    import exec_pkg::*;

    logic              enable_i;
    logic              wb_i;
    logic [OP_W-1:0]   opCode_i;
    logic [ADDR_W-1:0] regAddr_i;
    logic [DATA_W-1:0] primOperand_i;
    logic [DATA_W-1:0] secOperand_i;
    logic [1:0]        functionType_i;
    logic [1:0]        operationStatus_i;

    logic              wb_o;
    logic [ADDR_W-1:0] wbAddr_o;
    logic [DATA_W-1:0] wbVal_o;
    logic [1:0]        operationStatus_o;

    modport master (
        output enable_i, wb_i, opCode_i, regAddr_i, primOperand_i, secOperand_i,
               functionType_i, operationStatus_i,
        input  wb_o, wbAddr_o, wbVal_o, operationStatus_o
    );

    modport slave (
        input  enable_i, wb_i, opCode_i, regAddr_i, primOperand_i, secOperand_i,
               functionType_i, operationStatus_i,
        output wb_o, wbAddr_o, wbVal_o, operationStatus_o
    );

endinterface

// File: rtl/exec_mul_seq.sv
// Iterative shift-add multiplier consuming 4 multiplier bits per clock.
// The first nibble is folded in on the start edge, so done rises MUL_STEPS-1 edges later.
module exec_mul_seq
    import exec_pkg::*;
#(
    parameter int MUL_STEPS = 4
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start,
    input  logic                abort,
    input  logic [DATA_W-1:0]   multiplicand,
    input  logic [DATA_W-1:0]   multiplier,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);

    localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam int PRD_W = 2 * DATA_W;

    logic             running;
    logic [CNT_W-1:0] stepQ;
    logic [PRD_W-1:0] accQ;
    logic [PRD_W-1:0] mcandQ;
    logic [DATA_W-1:0] mplierQ;

    function automatic logic [PRD_W-1:0] partial(input logic [PRD_W-1:0] m, input logic [3:0] n);
        return m * {{(PRD_W-4){1'b0}}, n};
    endfunction

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            running <= 1'b0;
            done    <= 1'b0;
            stepQ   <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                running <= 1'b0;
            end else if (start) begin
                running <= (MUL_STEPS > 1);
                done    <= (MUL_STEPS == 1);
                stepQ   <= CNT_W'(1);
            end else if (running) begin
                stepQ <= stepQ + CNT_W'(1);
                if (stepQ == CNT_W'(MUL_STEPS - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    // Datapath: accumulator and shifted operands carry no reset, they are always reloaded on start
    always_ff @(posedge clock_i) begin
        if (start) begin
            accQ    <= partial({{DATA_W{1'b0}}, multiplicand}, multiplier[3:0]);
            mcandQ  <= {{(DATA_W-4){1'b0}}, multiplicand, 4'b0000};
            mplierQ <= multiplier >> 4;
        end else if (running) begin
            accQ    <= accQ + partial(mcandQ, mplierQ[3:0]);
            mcandQ  <= mcandQ << 4;
            mplierQ <= mplierQ >> 4;
        end
    end

    assign product = accQ;

endmodule

// File: rtl/exec_arith_port.sv
// Arithmetic execution port: single-cycle ALU ops through a one-stage pipeline,
// MUL through the iterative multiplier under a two-state FSM, with flush and sticky drop flag.
module exec_arith_port
    import exec_pkg::*;
#(
    parameter int MUL_STEPS = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    exec_arith_port_if.slave bus,
    output logic             busy_o,
    output logic             dropped_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    logic [0:0]          stateQ;
    logic                accept;
    logic                arithSel;
    logic                legalOp;
    logic                mulIssue;
    aluRes_t             aluRes;

    logic                mulDone;
    logic [2*DATA_W-1:0] mulProd;
    logic                mulWbQ;
    logic [ADDR_W-1:0]   mulAddrQ;

    logic                vld_p0;
    logic                ill_p0;
    logic                wbEn_p0;
    logic [ADDR_W-1:0]   addr_p0;
    aluRes_t             res_p0;

    logic                wbQ;
    logic [ADDR_W-1:0]   wbAddrQ;
    logic [DATA_W-1:0]   wbValQ;
    logic [1:0]          statusQ;
    logic                illegalQ;
    logic                droppedQ;
    logic                unusedZeroIn;

    function automatic aluRes_t aluCalc(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b, input logic cin);
        logic [DATA_W:0] wide;
        aluRes_t         r;
        case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_ADC:  wide = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_SHL:  wide = {1'b0, a << b[3:0]};
            OP_SHR:  wide = {1'b0, a >> b[3:0]};
            default: wide = '0;
        endcase
        r.val   = wide[DATA_W-1:0];
        r.carry = wide[DATA_W];
        r.zero  = (wide[DATA_W-1:0] == '0);
        return r;
    endfunction

    assign busy_o       = (stateQ == ST_MUL);
    assign accept       = bus.enable_i && !busy_o && !flush_i;
    assign arithSel     = (bus.functionType_i == FT_ARITH);
    assign legalOp      = isArithOp(bus.opCode_i);
    assign mulIssue     = accept && arithSel && (bus.opCode_i == OP_MUL);
    assign aluRes       = aluCalc(bus.opCode_i, bus.primOperand_i, bus.secOperand_i,
                                  bus.operationStatus_i[STAT_CARRY]);
    assign unusedZeroIn = bus.operationStatus_i[STAT_ZERO];

    exec_mul_seq #(
        .MUL_STEPS(MUL_STEPS)
    ) mulSeq (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .start        (mulIssue),
        .abort        (flush_i),
        .multiplicand (bus.primOperand_i),
        .multiplier   (bus.secOperand_i),
        .done         (mulDone),
        .product      (mulProd)
    );

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            stateQ   <= ST_IDLE;
            vld_p0   <= 1'b0;
            ill_p0   <= 1'b0;
            wbQ      <= 1'b0;
            wbAddrQ  <= '0;
            wbValQ   <= '0;
            statusQ  <= '0;
            illegalQ <= 1'b0;
            droppedQ <= 1'b0;
        end else begin
            if (bus.enable_i && busy_o) droppedQ <= 1'b1;
            // Stage p0: accepted single-cycle op waiting one edge for presentation
            vld_p0 <= accept && arithSel && legalOp &&
                      (bus.opCode_i != OP_NOP) && (bus.opCode_i != OP_MUL);
            ill_p0 <= accept && arithSel && !legalOp;
            // Output stage: flush kills everything that would be presented at this edge
            if (flush_i) begin
                stateQ   <= ST_IDLE;
                wbQ      <= 1'b0;
                illegalQ <= 1'b0;
            end else begin
                illegalQ <= ill_p0;
                if (stateQ == ST_MUL && mulDone) begin
                    stateQ              <= ST_IDLE;
                    wbQ                 <= mulWbQ;
                    wbAddrQ             <= mulAddrQ;
                    wbValQ              <= mulProd[DATA_W-1:0];
                    statusQ[STAT_CARRY] <= (mulProd[2*DATA_W-1:DATA_W] != '0);
                    statusQ[STAT_ZERO]  <= (mulProd[DATA_W-1:0] == '0);
                end else if (vld_p0) begin
                    wbQ                 <= wbEn_p0;
                    wbAddrQ             <= addr_p0;
                    wbValQ              <= res_p0.val;
                    statusQ[STAT_CARRY] <= res_p0.carry;
                    statusQ[STAT_ZERO]  <= res_p0.zero;
                end else begin
                    wbQ <= 1'b0;
                end
                if (mulIssue) stateQ <= ST_MUL;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (accept) begin
            wbEn_p0 <= bus.wb_i;
            addr_p0 <= bus.regAddr_i;
            res_p0  <= aluRes;
        end
        if (mulIssue) begin
            mulWbQ   <= bus.wb_i;
            mulAddrQ <= bus.regAddr_i;
        end
    end

    assign bus.wb_o              = wbQ;
    assign bus.wbAddr_o          = wbAddrQ;
    assign bus.wbVal_o           = wbValQ;
    assign bus.operationStatus_o = illegalQ ? 2'b11 : statusQ;
    assign dropped_o             = droppedQ;

endmodule

// File: tb/tb_exec_arith_port.sv
// Scoreboard bench for exec_arith_port: directed scenarios followed by randomized issue traffic.
module tb_exec_arith_port;
    import exec_pkg::*;

    localparam int MUL_STEPS = 4;

    logic clock_i = 1'b0;
    logic reset_i;
    logic flush_i = 1'b0;
    logic busy_o;
    logic dropped_o;

    exec_arith_port_if bus();

    exec_arith_port #(.MUL_STEPS(MUL_STEPS)) dut (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .flush_i   (flush_i),
        .bus       (bus),
        .busy_o    (busy_o),
        .dropped_o (dropped_o)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [15:0] val;
        logic [1:0]  stat;
    } exp_t;

    exp_t     expQ[$];
    exp_t     monE;
    int       errors = 0;
    int       checks = 0;
    bit       mulActive = 0;
    int       mulStart = 0;
    bit       expDropped = 0;
    logic [1:0] lastStat = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit expBusy(input int n);
        return mulActive && (n >= mulStart) && (n < mulStart + MUL_STEPS);
    endfunction

    // Reference model: plain integer arithmetic on unsigned operand values.
    function automatic void refModel(input logic [6:0] op, input logic [15:0] a, input logic [15:0] b,
                                     input logic cin, output logic [15:0] val, output logic [1:0] stat,
                                     output bit legal);
        longint x, y, r;
        bit     carry;
        x = a; y = b; r = 0; carry = 0; legal = 1;
        case (op)
            7'd1: begin r = x + y; carry = (r > 65535); end
            7'd2: begin r = x - y; carry = (x < y); if (r < 0) r = r + 65536; end
            7'd3: r = x & y;
            7'd4: r = x | y;
            7'd5: r = x ^ y;
            7'd6: r = x * (2 ** (y % 16));
            7'd7: r = x / (2 ** (y % 16));
            7'd8: begin r = x * y; carry = (r > 65535); end
            7'd9: begin r = x + y + (cin ? 1 : 0); carry = (r > 65535); end
            7'd0: r = 0;
            default: legal = 0;
        endcase
        r    = r % 65536;
        val  = r[15:0];
        stat = {(val == 16'h0000), carry};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clock_i);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] addr, input logic wb, input logic [1:0] ft, input logic cin);
        logic [15:0] val;
        logic [1:0]  st;
        bit          legal, busyBefore;
        int          n;
        exp_t        e;
        bus.enable_i          = 1'b1;
        bus.wb_i              = wb;
        bus.opCode_i          = op;
        bus.regAddr_i         = addr;
        bus.primOperand_i     = a;
        bus.secOperand_i      = b;
        bus.functionType_i    = ft;
        bus.operationStatus_i = {1'($urandom_range(0, 1)), cin};
        @(posedge clock_i);
        #1;
        n = cyc;
        bus.enable_i = 1'b0;
        busyBefore = expBusy(n - 1);
        if (busyBefore) expDropped = 1;
        if (!busyBefore && ft == 2'd0) begin
            refModel(op, a, b, cin, val, st, legal);
            if (legal && op != 7'd0) begin
                if (op == 7'd8) begin
                    mulActive = 1;
                    mulStart  = n;
                end
                if (wb) begin
                    e.cyc  = n + ((op == 7'd8) ? MUL_STEPS : 1);
                    e.addr = addr;
                    e.val  = val;
                    e.stat = st;
                    expQ.push_back(e);
                end
                lastStat = st;
            end
        end
        check("busy_o after issue", busy_o, expBusy(n));
        check("dropped_o after issue", dropped_o, expDropped);
    endtask

    task automatic flushOp();
        int   f;
        exp_t keep[$];
        flush_i = 1'b1;
        @(posedge clock_i);
        #1;
        f = cyc;
        flush_i = 1'b0;
        foreach (expQ[i]) if (expQ[i].cyc < f) keep.push_back(expQ[i]);
        expQ = keep;
        mulActive = 0;
        check("busy_o after flush", busy_o, 0);
    endtask

    // Monitor: every writeback strobe must match the oldest outstanding expectation.
    always @(negedge clock_i) begin
        if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            monE = expQ.pop_front();
            check("missing wb_o", 0, 1);
        end
        if (bus.wb_o === 1'b1) begin
            if (expQ.size() == 0) begin
                check("unexpected wb_o", 1, 0);
            end else begin
                monE = expQ.pop_front();
                check("wb_o cycle", cyc, monE.cyc);
                check("wbAddr_o", bus.wbAddr_o, monE.addr);
                check("wbVal_o", bus.wbVal_o, monE.val);
                check("operationStatus_o", bus.operationStatus_o, monE.stat);
            end
        end
    end

    initial begin
        logic [6:0]  op;
        logic [15:0] a, b;
        int          sel;
        bus.enable_i = 0; bus.wb_i = 0; bus.opCode_i = 0; bus.regAddr_i = 0;
        bus.primOperand_i = 0; bus.secOperand_i = 0; bus.functionType_i = 0;
        bus.operationStatus_i = 0;
        reset_i = 1'b1;
        #2 reset_i = 1'b0;
        #1;
        check("reset wb_o", bus.wb_o, 0);
        check("reset wbAddr_o", bus.wbAddr_o, 0);
        check("reset wbVal_o", bus.wbVal_o, 0);
        check("reset operationStatus_o", bus.operationStatus_o, 0);
        check("reset busy_o", busy_o, 0);
        check("reset dropped_o", dropped_o, 0);
        idle(2);
        reset_i = 1'b1;

        // ADD overflow to zero
        issue(OP_ADD, 16'hFFFF, 16'h0001, 5'd5, 1'b1, FT_ARITH, 1'b0);
        idle(2);

        // MUL with busy window
        issue(OP_MUL, 16'h0100, 16'h0101, 5'd3, 1'b1, FT_ARITH, 1'b0);
        for (int k = 0; k < MUL_STEPS; k++) begin
            idle(1);
            check("busy_o during MUL", busy_o, expBusy(cyc));
        end
        idle(2);

        // ADD issued while MUL is busy is lost
        issue(OP_MUL, 16'h1234, 16'h0010, 5'd9, 1'b1, FT_ARITH, 1'b0);
        issue(OP_ADD, 16'h0001, 16'h0002, 5'd10, 1'b1, FT_ARITH, 1'b0);
        idle(MUL_STEPS + 2);
        check("dropped_o sticky", dropped_o, 1);

        // Illegal opcode: one-cycle 2'b11 status, no writeback
        issue(OP_ADD, 16'h0001, 16'h0001, 5'd7, 1'b1, FT_ARITH, 1'b0);
        idle(2);
        issue(7'h55, 16'h1111, 16'h2222, 5'd8, 1'b1, FT_ARITH, 1'b0);
        idle(1);
        check("illegal status pulse", bus.operationStatus_o, 2'b11);
        check("illegal wb_o", bus.wb_o, 0);
        idle(1);
        check("status after illegal", bus.operationStatus_o, lastStat);

        // Flush at MUL step 2, then SUB 3-5
        issue(OP_MUL, 16'h0F0F, 16'h0303, 5'd11, 1'b1, FT_ARITH, 1'b0);
        idle(1);
        flushOp();
        issue(OP_SUB, 16'd3, 16'd5, 5'd4, 1'b1, FT_ARITH, 1'b0);
        idle(MUL_STEPS + 2);

        // Reset mid-MUL, then ADC 1+1+carry
        issue(OP_MUL, 16'hFFFF, 16'hFFFF, 5'd2, 1'b1, FT_ARITH, 1'b0);
        idle(1);
        reset_i = 1'b0;
        #1;
        expQ.delete();
        mulActive = 0;
        expDropped = 0;
        check("mid-MUL reset wb_o", bus.wb_o, 0);
        check("mid-MUL reset wbAddr_o", bus.wbAddr_o, 0);
        check("mid-MUL reset wbVal_o", bus.wbVal_o, 0);
        check("mid-MUL reset operationStatus_o", bus.operationStatus_o, 0);
        check("mid-MUL reset busy_o", busy_o, 0);
        check("mid-MUL reset dropped_o", dropped_o, 0);
        idle(2);
        reset_i = 1'b1;
        issue(OP_ADC, 16'd1, 16'd1, 5'd6, 1'b1, FT_ARITH, 1'b1);
        idle(MUL_STEPS + 2);

        // Randomized traffic with back-to-back issues, gaps and occasional flushes
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 12);
            if (sel <= 9)       op = 7'(sel);
            else if (sel == 10) op = 7'($urandom_range(10, 127));
            else                op = OP_MUL;
            case ($urandom_range(0, 3))
                0:       a = 16'h0000;
                1:       a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       b = 16'h0000;
                1:       b = 16'hFFFF;
                default: b = 16'($urandom);
            endcase
            issue(op, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : FT_ARITH,
                  1'($urandom_range(0, 1)));
            if ($urandom_range(0, 24) == 0) flushOp();
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 5));
        end
        idle(MUL_STEPS + 4);
        check("results still pending", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
